// File: rtl/dac_spi_writer.sv
// SPI frame writer for a 16-bit DAC: accepts one sample per valid/ready handshake, shifts
// {command, code} out MSB first, then pulses LDAC so the DAC output updates.
module dac_spi_writer #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CMD_BITS      = 8,
  parameter logic [15:0] CMD_WORD      = 16'h0030,
  parameter bit          OFFSET_BINARY = 1'b1,
  parameter int unsigned LDAC_CYCLES   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        sclk_out,
  output logic        sdi_out,
  output logic        cs_n_out,
  output logic        ldac_n_out,
  output logic [15:0] frame_count_out
);

  localparam int unsigned   FrameBits = CMD_BITS + 16;
  localparam int unsigned   CntW      = 16;
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] LdacLen = CntW'(LDAC_CYCLES);
  localparam logic [5:0]    BitLast   = 6'(FrameBits - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCsHold, StLoad} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [5:0]           bit_q, bit_d;
  logic [FrameBits-1:0] shreg_q, shreg_d;
  logic                 sclk_q, sclk_d;
  logic                 sdi_q, sdi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 ldac_n_q, ldac_n_d;
  logic                 ready_q, ready_d;
  logic [15:0]          frame_count_q, frame_count_d;

  logic [15:0]          code;
  logic [FrameBits-1:0] frame;

  // Command bits above CMD_BITS fall off the top of the frame word.
  always_comb begin
    code  = OFFSET_BINARY ? (data_in ^ 16'h8000) : data_in;
    frame = (FrameBits'(CMD_WORD) << 16) | FrameBits'(code);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    sclk_d        = sclk_q;
    sdi_d         = sdi_q;
    cs_n_d        = cs_n_q;
    ldac_n_d      = ldac_n_q;
    ready_d       = 1'b0;
    frame_count_d = frame_count_q;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (valid_in && ready_q) begin
          state_d = StShift;
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          sdi_d   = frame[FrameBits-1];
          shreg_d = frame << 1;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end

      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: the only place sdi is allowed to move.
            sclk_d = 1'b0;
            if (bit_q == BitLast) begin
              state_d = StCsHold;
            end else begin
              bit_d   = bit_q + 6'd1;
              sdi_d   = shreg_q[FrameBits-1];
              shreg_d = shreg_q << 1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StCsHold: begin
        if (cnt_q == DivLast) begin
          state_d       = StLoad;
          cnt_d         = '0;
          cs_n_d        = 1'b1;
          sdi_d         = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StLoad: begin
        // First LOAD cycle leaves a gap after cs_n rises before LDAC drops.
        if (cnt_q == LdacLen) begin
          state_d  = StIdle;
          ldac_n_d = 1'b1;
          ready_d  = 1'b1;
          cnt_d    = '0;
        end else begin
          ldac_n_d = 1'b0;
          cnt_d    = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      sclk_q        <= 1'b0;
      sdi_q         <= 1'b0;
      cs_n_q        <= 1'b1;
      ldac_n_q      <= 1'b1;
      ready_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      sclk_q        <= sclk_d;
      sdi_q         <= sdi_d;
      cs_n_q        <= cs_n_d;
      ldac_n_q      <= ldac_n_d;
      ready_q       <= ready_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign ready_out       = ready_q;
  assign sclk_out        = sclk_q;
  assign sdi_out         = sdi_q;
  assign cs_n_out        = cs_n_q;
  assign ldac_n_out      = ldac_n_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: two instances (default and minimal parameters) checked every cycle
// against a cycle-offset waveform model computed from the accept time and the frame word.
module tb_dac_spi_writer;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [1:0][15:0] data;
  logic [1:0]       valid;
  logic [1:0]       ready, sclk, sdi, cs_n, ldac_n;
  logic [1:0][15:0] fcnt;

  always #5 clk_in = ~clk_in;

  dac_spi_writer dut_a (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data[0]),
    .valid_in       (valid[0]),
    .ready_out      (ready[0]),
    .sclk_out       (sclk[0]),
    .sdi_out        (sdi[0]),
    .cs_n_out       (cs_n[0]),
    .ldac_n_out     (ldac_n[0]),
    .frame_count_out(fcnt[0])
  );

  dac_spi_writer #(
    .CLK_DIV      (1),
    .CMD_BITS     (0),
    .OFFSET_BINARY(1'b0),
    .LDAC_CYCLES  (1)
  ) dut_b (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data[1]),
    .valid_in       (valid[1]),
    .ready_out      (ready[1]),
    .sclk_out       (sclk[1]),
    .sdi_out        (sdi[1]),
    .cs_n_out       (cs_n[1]),
    .ldac_n_out     (ldac_n[1]),
    .frame_count_out(fcnt[1])
  );

  // Instance parameters as seen by the model.
  int cd [2] = '{2, 1};
  int cb [2] = '{8, 0};
  int lc [2] = '{2, 1};
  int ob [2] = '{1, 0};
  int cmd[2] = '{32'h30, 32'h30};

  logic [15:0] dir_tab[2][4] = '{'{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF},
                                 '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000}};

  // m_k: -1 = just out of reset, 0 = idle/ready, n>0 = n cycles after the accept edge.
  int          m_k[2];
  logic [31:0] m_frame[2];
  logic [15:0] m_cnt[2];
  int          dir_idx[2];
  int          n_total;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_bits(input int d);
    return cb[d] + 16;
  endfunction

  function automatic int cs_rise(input int d);
    return 2 * frame_bits(d) * cd[d] + cd[d] + 1;
  endfunction

  task automatic check_dut(input int d);
    int k, s, i, r;
    logic e_sclk, e_sdi, e_cs_n, e_ldac_n, e_ready;
    k = m_k[d];
    s = 2 * frame_bits(d) * cd[d];
    e_sclk = 1'b0; e_sdi = 1'b0; e_cs_n = 1'b1; e_ldac_n = 1'b1;
    e_ready = (k == 0);
    if (k >= 1) begin
      if (k <= s) begin
        i = (k - 1) / (2 * cd[d]);
        r = (k - 1) % (2 * cd[d]);
        e_sclk = (r >= cd[d]);
        e_sdi  = m_frame[d][frame_bits(d) - 1 - i];
        e_cs_n = 1'b0;
      end else if (k <= s + cd[d]) begin
        e_sdi  = m_frame[d][0];
        e_cs_n = 1'b0;
      end else if (k >= cs_rise(d) + 1) begin
        e_ldac_n = 1'b0;
      end
    end
    check($sformatf("sclk[%0d]", d),   32'(sclk[d]),   32'(e_sclk));
    check($sformatf("sdi[%0d]", d),    32'(sdi[d]),    32'(e_sdi));
    check($sformatf("cs_n[%0d]", d),   32'(cs_n[d]),   32'(e_cs_n));
    check($sformatf("ldac_n[%0d]", d), 32'(ldac_n[d]), 32'(e_ldac_n));
    check($sformatf("ready[%0d]", d),  32'(ready[d]),  32'(e_ready));
    check($sformatf("fcnt[%0d]", d),   32'(fcnt[d]),   32'(m_cnt[d]));
  endtask

  task automatic model_step(input int d, input logic v, input logic [15:0] dat);
    int code;
    if (m_k[d] == -1) begin
      m_k[d] = 0;
    end else if (m_k[d] == 0) begin
      if (v) begin
        code = (ob[d] != 0) ? ((int'(dat) + 32768) % 65536) : int'(dat);
        m_frame[d] = ((32'(cmd[d]) & ((32'd1 << cb[d]) - 32'd1)) << 16) | 32'(code);
        m_k[d] = 1;
        if (dir_idx[d] < 4) dir_idx[d]++;
      end
    end else begin
      m_k[d]++;
      if (m_k[d] == cs_rise(d)) m_cnt[d] = m_cnt[d] + 16'd1;
      if (m_k[d] == cs_rise(d) + lc[d] + 1) m_k[d] = 0;
    end
  endtask

  task automatic drive(input bit rand_valid);
    for (int d = 0; d < 2; d++) begin
      if (dir_idx[d] < 4) begin
        data[d]  = dir_tab[d][dir_idx[d]];
        valid[d] = 1'b1;
      end else begin
        data[d]  = 16'($urandom);
        valid[d] = rand_valid ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic [1:0]       v;
    logic [1:0][15:0] dd;
    v  = valid;
    dd = data;
    @(posedge clk_in);
    #1;
    if (!rst_in) begin
      for (int d = 0; d < 2; d++) model_step(d, v[d], dd[d]);
    end
    for (int d = 0; d < 2; d++) check_dut(d);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    valid   = '0;
    data    = '0;
    for (int d = 0; d < 2; d++) begin
      m_k[d] = -1; m_cnt[d] = '0; m_frame[d] = '0; dir_idx[d] = 0;
    end

    #12;
    for (int d = 0; d < 2; d++) check_dut(d);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Directed code-conversion samples, then free-running valid held high.
    for (int i = 0; i < 500; i++) begin drive(1'b0); tick(); end
    for (int i = 0; i < 1500; i++) begin drive(1'b1); tick(); end

    // Reset in the middle of a frame on the default instance.
    for (int i = 0; i < 300 && m_k[0] != 40; i++) begin drive(1'b1); tick(); end
    check("midframe_reach", 32'(m_k[0]), 32'd40);
    rst_in = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin m_k[d] = -1; m_cnt[d] = '0; end
    for (int d = 0; d < 2; d++) check_dut(d);
    tick();
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 300; i++) begin drive(1'b1); tick(); end

    // Counter wrap: preload both counters while idle.
    valid = '0;
    for (int i = 0; i < 200 && (m_k[0] != 0 || m_k[1] != 0); i++) tick();
    force dut_a.frame_count_q = 16'hFFFE;
    force dut_b.frame_count_q = 16'hFFFE;
    m_cnt[0] = 16'hFFFE;
    m_cnt[1] = 16'hFFFE;
    tick();
    release dut_a.frame_count_q;
    release dut_b.frame_count_q;
    for (int i = 0; i < 320; i++) begin drive(1'b1); tick(); end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
